// File: rtl/vminmax_reduce.sv
// Vector min/max unit: lane-wise vmin/vmax with byte-mask, plus optional multi-beat vredmin/vredmax.
// Latency: 2 cycles from the input register to out_* for elementwise beats and for the last reduction beat.
// Backpressure: none; valid-only, accepts one beat every cycle and never stalls.
// Optional reduction datapath (acc, seed, busy, tree) is built only when VMINMAX_RED_EN is defined.
module vminmax_reduce #(
  parameter int DATA_WIDTH = 64,
  parameter int SEW_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_vec0,
  input  logic [DATA_WIDTH-1:0]   in_vec1,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic [SEW_WIDTH-1:0]    in_sew,
  input  logic                    in_max,
  input  logic                    in_signed,
  input  logic                    in_red,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_lt,
  output logic [DATA_WIDTH/8-1:0] out_eq
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;

  // Sign- or zero-extend the low SEW bits of a right-aligned element to SEW+1 (held in 65 bits).
  function automatic logic signed [64:0] ext65(input logic [63:0] v, input logic [1:0] sew,
                                               input logic sgn);
    logic signed [64:0] r;
    case (sew)
      2'd0:    r = {{57{sgn & v[7]}}, v[7:0]};
      2'd1:    r = {{49{sgn & v[15]}}, v[15:0]};
      2'd2:    r = {{33{sgn & v[31]}}, v[31:0]};
      default: r = {sgn & v[63], v};
    endcase
    return r;
  endfunction

  // Lowest byte index of the element that contains byte i.
  function automatic logic [IDXW-1:0] elem_base(input int i, input logic [1:0] sew);
    return IDXW'((i >> sew) << sew);
  endfunction

  // Per-byte A<B flag, evaluated at each element's lowest byte and replicated over the element.
  function automatic logic [NB-1:0] elem_lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                            input logic [1:0] sew, input logic sgn);
    logic [DATA_WIDTH+55:0] pa, pb;
    logic [NB-1:0]          lo, r;
    pa = {56'd0, a};
    pb = {56'd0, b};
    for (int i = 0; i < NB; i++) lo[i] = ext65(pa[i*8 +: 64], sew, sgn) < ext65(pb[i*8 +: 64], sew, sgn);
    for (int i = 0; i < NB; i++) r[i] = lo[elem_base(i, sew)];
    return r;
  endfunction

  // Per-byte A==B flag, same replication as elem_lt.
  function automatic logic [NB-1:0] elem_eq(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                            input logic [1:0] sew);
    logic [DATA_WIDTH+55:0] pa, pb;
    logic [NB-1:0]          lo, r;
    pa = {56'd0, a};
    pb = {56'd0, b};
    for (int i = 0; i < NB; i++) lo[i] = ext65(pa[i*8 +: 64], sew, 1'b0) == ext65(pb[i*8 +: 64], sew, 1'b0);
    for (int i = 0; i < NB; i++) r[i] = lo[elem_base(i, sew)];
    return r;
  endfunction

  // An element is active when the mask bit of its lowest byte is set; replicated per byte.
  function automatic logic [NB-1:0] act_bytes(input logic [NB-1:0] mask, input logic [1:0] sew);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = mask[elem_base(i, sew)];
    return r;
  endfunction

  // Lane-wise min/max; inactive lanes pass B through. Ties pick A for min, A for max.
  function automatic logic [DATA_WIDTH-1:0] sel_minmax(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b,
                                                       input logic [1:0] sew, input logic mx,
                                                       input logic sgn, input logic [NB-1:0] act);
    logic [NB-1:0]         lt, eq;
    logic [DATA_WIDTH-1:0] r;
    logic                  pick_a;
    lt = elem_lt(a, b, sew, sgn);
    eq = elem_eq(a, b, sew);
    for (int i = 0; i < NB; i++) begin
      pick_a        = act[i] & (mx ? ~lt[i] : (lt[i] | eq[i]));
      r[i*8 +: 8]   = pick_a ? a[i*8 +: 8] : b[i*8 +: 8];
    end
    return r;
  endfunction

  // Stage 0: input register. Payload only loads on valid beats so idle cycles leave it untouched.
  logic                  r_vld_q;
  logic [DATA_WIDTH-1:0] r_vec0_q, r_vec1_q;
  logic [NB-1:0]         r_mask_q;
  logic [1:0]            r_sew_q;
  logic                  r_max_q, r_sgn_q;

  // Stage 1: elementwise operands with their resolved per-byte activity.
  logic                  m_ew_q, m_ew_d;
  logic [DATA_WIDTH-1:0] m_a_q, m_b_q;
  logic [NB-1:0]         m_act_q, ew_act;
  logic [1:0]            m_sew_q;
  logic                  m_max_q, m_sgn_q;

  // Stage 2 outputs.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NB-1:0]         out_lt_q, out_lt_d, out_eq_q, out_eq_d;

  // Capture the incoming beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_q  <= 1'b0;
      r_vec0_q <= '0;
      r_vec1_q <= '0;
      r_mask_q <= '0;
      r_sew_q  <= '0;
      r_max_q  <= 1'b0;
      r_sgn_q  <= 1'b0;
    end else begin
      r_vld_q <= in_valid;
      if (in_valid) begin
        r_vec0_q <= in_vec0;
        r_vec1_q <= in_vec1;
        r_mask_q <= in_mask;
        r_sew_q  <= in_sew[1:0];
        r_max_q  <= in_max;
        r_sgn_q  <= in_signed;
      end
    end
  end

  // Resolve element activity for elementwise beats.
  always_comb begin
    ew_act = act_bytes(r_mask_q, r_sew_q);
  end

`ifdef VMINMAX_RED_EN
  localparam int LOG_NB = $clog2(NB);

  // Low SEW bits of a 64-bit element.
  function automatic logic [63:0] elem_mask(input logic [1:0] sew);
    case (sew)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Neutral element for the reduction: any real value beats it in the compare.
  function automatic logic [DATA_WIDTH-1:0] identity(input logic [1:0] sew, input logic mx, input logic sgn);
    logic [DATA_WIDTH-1:0] r;
    logic                  top;
    for (int i = 0; i < NB; i++) begin
      top         = (((i + 1) & ((1 << sew) - 1)) == 0);
      r[i*8 +: 8] = mx ? ((sgn && top) ? 8'h80 : 8'h00) : ((sgn && top) ? 8'h7F : 8'hFF);
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] expand(input logic [NB-1:0] act);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = {8{act[i]}};
    return r;
  endfunction

  logic                  r_red_q, r_last_q;
  logic                  m_red_q, m_red_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [63:0]           seed_q, seed_d;
  logic                  busy_q, busy_d;
  logic [1:0]            cfg_sew_q, cfg_sew_d;
  logic                  cfg_max_q, cfg_max_d, cfg_sgn_q, cfg_sgn_d;
  logic                  red_beat, first;
  logic [1:0]            eff_sew;
  logic                  eff_max, eff_sgn;
  logic [DATA_WIDTH-1:0] red_msk, masked, tree_v, seed_v, red_fin, red_res;

  // Reduction flags travel with the beat through the input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red_q  <= 1'b0;
      r_last_q <= 1'b0;
    end else if (in_valid) begin
      r_red_q  <= in_red;
      r_last_q <= in_last;
    end
  end

  // Accumulator update: a first beat seeds acc with the identity-masked vector, later beats fold in.
  always_comb begin
    red_beat  = r_vld_q & r_red_q;
    first     = red_beat & ~busy_q;
    eff_sew   = first ? r_sew_q : cfg_sew_q;
    eff_max   = first ? r_max_q : cfg_max_q;
    eff_sgn   = first ? r_sgn_q : cfg_sgn_q;
    red_msk   = expand(act_bytes(r_mask_q, eff_sew));
    masked    = (r_vec0_q & red_msk) | (identity(eff_sew, eff_max, eff_sgn) & ~red_msk);
    acc_d     = acc_q;
    seed_d    = seed_q;
    busy_d    = busy_q;
    cfg_sew_d = cfg_sew_q;
    cfg_max_d = cfg_max_q;
    cfg_sgn_d = cfg_sgn_q;
    m_red_d   = red_beat & r_last_q;
    m_ew_d    = r_vld_q & ~r_red_q;
    if (red_beat) begin
      busy_d = ~r_last_q;
      if (first) begin
        acc_d     = masked;
        seed_d    = r_vec1_q[63:0] & elem_mask(r_sew_q);
        cfg_sew_d = r_sew_q;
        cfg_max_d = r_max_q;
        cfg_sgn_d = r_sgn_q;
      end else begin
        acc_d = sel_minmax(acc_q, masked, cfg_sew_q, cfg_max_q, cfg_sgn_q, {NB{1'b1}});
      end
    end
  end

  // Reduction state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_red_q   <= 1'b0;
      acc_q     <= '0;
      seed_q    <= '0;
      busy_q    <= 1'b0;
      cfg_sew_q <= '0;
      cfg_max_q <= 1'b0;
      cfg_sgn_q <= 1'b0;
    end else begin
      m_red_q   <= m_red_d;
      acc_q     <= acc_d;
      seed_q    <= seed_d;
      busy_q    <= busy_d;
      cfg_sew_q <= cfg_sew_d;
      cfg_max_q <= cfg_max_d;
      cfg_sgn_q <= cfg_sgn_d;
    end
  end

  // Halving tree over acc: each level folds the upper half onto the lower half until one element
  // remains; upper-half garbage never propagates into the low lanes that survive.
  always_comb begin
    tree_v = acc_q;
    for (int l = 0; l < LOG_NB; l++) begin
      if ((DATA_WIDTH >> (l + 1)) >= (8 << cfg_sew_q))
        tree_v = sel_minmax(tree_v, tree_v >> (DATA_WIDTH >> (l + 1)), cfg_sew_q, cfg_max_q, cfg_sgn_q,
                            {NB{1'b1}});
    end
    seed_v         = '0;
    seed_v[63:0]   = seed_q;
    red_fin        = sel_minmax(tree_v, seed_v, cfg_sew_q, cfg_max_q, cfg_sgn_q, {NB{1'b1}});
    red_res        = '0;
    red_res[63:0]  = red_fin[63:0] & elem_mask(cfg_sew_q);
  end
`else
  logic m_red_q;
  logic [DATA_WIDTH-1:0] red_res;
  logic unused_red;

  // Without the reduction datapath every beat is elementwise.
  always_comb begin
    m_ew_d     = r_vld_q;
    m_red_q    = 1'b0;
    red_res    = '0;
    unused_red = in_red ^ in_last;
  end
`endif

  // Stage 1 register for the elementwise operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ew_q  <= 1'b0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      m_act_q <= '0;
      m_sew_q <= '0;
      m_max_q <= 1'b0;
      m_sgn_q <= 1'b0;
    end else begin
      m_ew_q <= m_ew_d;
      if (m_ew_d) begin
        m_a_q   <= r_vec0_q;
        m_b_q   <= r_vec1_q;
        m_act_q <= ew_act;
        m_sew_q <= r_sew_q;
        m_max_q <= r_max_q;
        m_sgn_q <= r_sgn_q;
      end
    end
  end

  // Stage 2: pick the elementwise result or the reduced element; flags are zero for reductions.
  always_comb begin
    out_valid_d = m_ew_q | m_red_q;
    out_data_d  = out_data_q;
    out_lt_d    = out_lt_q;
    out_eq_d    = out_eq_q;
    if (m_ew_q) begin
      out_data_d = sel_minmax(m_a_q, m_b_q, m_sew_q, m_max_q, m_sgn_q, m_act_q);
      out_lt_d   = elem_lt(m_a_q, m_b_q, m_sew_q, m_sgn_q);
      out_eq_d   = elem_eq(m_a_q, m_b_q, m_sew_q);
    end else if (m_red_q) begin
      out_data_d = red_res;
      out_lt_d   = '0;
      out_eq_d   = '0;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lt_q    <= '0;
      out_eq_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lt_q    <= out_lt_d;
      out_eq_q    <= out_eq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lt    = out_lt_q;
  assign out_eq    = out_eq_q;

endmodule

// File: tb/tb_vminmax_reduce.sv
module tb_vminmax_reduce;
  localparam int DW = 64;
  localparam int NB = 8;
`ifdef VMINMAX_RED_EN
  localparam bit RED_EN = 1'b1;
`else
  localparam bit RED_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_vec0 = '0, in_vec1 = '0;
  logic [NB-1:0] in_mask = '0;
  logic [1:0]    in_sew = '0;
  logic          in_max = 1'b0, in_signed = 1'b0, in_red = 1'b0, in_last = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_lt, out_eq;

  always #5 clk = ~clk;

  vminmax_reduce #(.DATA_WIDTH(DW), .SEW_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec0(in_vec0), .in_vec1(in_vec1),
    .in_mask(in_mask), .in_sew(in_sew), .in_max(in_max), .in_signed(in_signed), .in_red(in_red),
    .in_last(in_last), .out_valid(out_valid), .out_data(out_data), .out_lt(out_lt), .out_eq(out_eq)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Expected output for the beat driven at cycle c lives in slot c%8 and is due 3 negedges later.
  logic          e_vld [8];
  logic [DW-1:0] e_dat [8];
  logic [NB-1:0] e_lt [8], e_eq [8];

  // Reduction model: config latched on the first beat, every active element collected in a queue.
  bit              m_busy = 1'b0;
  int              m_sew = 0;
  bit              m_max = 1'b0, m_sgn = 1'b0;
  longint unsigned m_seed = 0;
  longint unsigned m_vals [$];

  function automatic longint unsigned elem(input logic [63:0] v, input int e, input int sew);
    int          nb = 8 << sew;
    logic [63:0] s  = v >> (e * nb);
    if (nb == 64) return s;
    return s & ((64'd1 << nb) - 64'd1);
  endfunction

  function automatic bit less(input longint unsigned x, input longint unsigned y, input int sew, input bit sgn);
    int     sh = 64 - (8 << sew);
    longint sx, sy;
    if (!sgn) return x < y;
    sx = longint'(x << sh) >>> sh;
    sy = longint'(y << sh) >>> sh;
    return sx < sy;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_slot();
    int idx = (cyc + 5) % 8;
    chk("out_valid", 64'(out_valid), 64'(e_vld[idx]));
    if (e_vld[idx]) begin
      chk("out_data", out_data, e_dat[idx]);
      chk("out_lt", 64'(out_lt), 64'(e_lt[idx]));
      chk("out_eq", 64'(out_eq), 64'(e_eq[idx]));
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 8; i++) begin
      e_vld[i] = 1'b0; e_dat[i] = '0; e_lt[i] = '0; e_eq[i] = '0;
    end
  endtask

  // One clock of stimulus: check the due output, drive the beat, record what the model expects.
  task automatic beat(input bit v, input logic [63:0] a, input logic [63:0] b, input logic [7:0] m,
                      input int sew, input bit mx, input bit sg, input bit rd, input bit ls);
    logic            ev = 1'b0;
    logic [63:0]     d = '0;
    logic [7:0]      lt = '0, eq = '0;
    longint unsigned x, y, best;
    bit              l, q, act;
    int              nby;
    @(negedge clk);
    check_slot();
    in_valid = v; in_vec0 = a; in_vec1 = b; in_mask = m; in_sew = 2'(sew);
    in_max = mx; in_signed = sg; in_red = rd; in_last = ls;
    if (v) begin
      if (RED_EN && rd) begin
        if (!m_busy) begin
          m_sew = sew; m_max = mx; m_sgn = sg; m_seed = elem(b, 0, sew);
          m_vals.delete();
        end
        for (int e = 0; e < (8 >> m_sew); e++)
          if (m[e << m_sew]) m_vals.push_back(elem(a, e, m_sew));
        if (ls) begin
          best = m_seed;
          foreach (m_vals[k]) begin
            if (m_max ? less(best, m_vals[k], m_sew, m_sgn) : less(m_vals[k], best, m_sew, m_sgn))
              best = m_vals[k];
          end
          ev = 1'b1; d = best; m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end else begin
        ev  = 1'b1;
        nby = 1 << sew;
        for (int e = 0; e < (8 >> sew); e++) begin
          x   = elem(a, e, sew);
          y   = elem(b, e, sew);
          l   = less(x, y, sew, sg);
          q   = (x == y);
          act = m[e * nby];
          d   = d | ((act ? (mx ? (l ? y : x) : ((l || q) ? x : y)) : y) << (e * (8 << sew)));
          for (int k = 0; k < nby; k++) begin
            lt[e * nby + k] = l;
            eq[e * nby + k] = q;
          end
        end
      end
    end
    e_vld[cyc % 8] = ev; e_dat[cyc % 8] = d; e_lt[cyc % 8] = lt; e_eq[cyc % 8] = eq;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, '0, '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_lt"}, 64'(out_lt), 64'd0);
    chk({tag, "_eq"}, 64'(out_eq), 64'd0);
    clear_slots();
    m_busy = 1'b0;
    m_vals.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a, b;
    logic [7:0]  m;
    bit          rd, ls;
    clear_slots();
    rst_pulse("reset");

    // Signed then unsigned SEW8 min of 0x80 vs 0x7F.
    beat(1, 64'h80, 64'h7F, 8'hFF, 0, 0, 1, 0, 0);
    beat(1, 64'h80, 64'h7F, 8'hFF, 0, 0, 0, 0, 0);
    // SEW16 max with lane 1 masked off.
    beat(1, 64'h0000_0000_0009_0005, 64'h0000_0000_0003_0007, 8'hFB, 1, 1, 0, 0, 0);
    // 3-beat unsigned SEW32 max reduction, seed 6.
    beat(1, {32'd2, 32'd1}, 64'd6, 8'hFF, 2, 1, 0, 1, 0);
    beat(1, {32'd4, 32'd9}, 64'd6, 8'hFF, 2, 1, 0, 1, 0);
    beat(1, {32'd8, 32'd3}, 64'd6, 8'hFF, 2, 1, 0, 1, 1);
    // Single-beat signed SEW64 min, with and without the element active.
    beat(1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 8'hFF, 3, 0, 1, 1, 1);
    beat(1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 8'h00, 3, 0, 1, 1, 1);
    // Elementwise beat interleaved into a signed SEW8 max reduction.
    beat(1, 64'h05F0_7F80_0102_0304, 64'h11, 8'hF0, 0, 1, 1, 1, 0);
    beat(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_0000_9ABC_FFFF, 8'hFF, 1, 0, 1, 0, 0);
    beat(1, 64'h8081_8283_8485_8687, 64'h0, 8'hFF, 2, 0, 0, 1, 0);
    beat(1, 64'h0000_0000_0000_0060, 64'h0, 8'h01, 3, 0, 0, 1, 1);
    idle(3);
    // Reset in the middle of a reduction, then a fresh single-beat max.
    beat(1, 64'h7777, 64'h1, 8'hFF, 0, 1, 0, 1, 0);
    rst_pulse("midrst");
    beat(1, 64'h10, 64'h20, 8'hFF, 0, 1, 0, 1, 1);
    idle(3);

    // Randomized mix of elementwise beats, reductions and idle cycles.
    for (int i = 0; i < 400; i++) begin
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b[31:0] = a[31:0];
      m  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      rd = ($urandom_range(0, 2) == 0);
      ls = ($urandom_range(0, 2) == 0);
      beat($urandom_range(0, 7) != 0, a, b, m, $urandom_range(0, 3), 1'($urandom), 1'($urandom), rd, ls);
    end
    if (m_busy) beat(1, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, 0, 0, 0, 1, 1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
